// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory arbiter slice.
//   state_t   : arbiter FSM states (IDLE, ACCESS, DONE)
//   AW_DEF    : default memory address width
//   DW_DEF    : default memory data width
//   MEM_DEPTH : number of words in the main memory
package mem_arb_pkg;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 16;
  localparam int MEM_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the arbiter.
//   Requester side : req, req_we, req_addr, req_wdata (flattened, requester i
//                    at [i*AW +: AW] / [i*DW +: DW]); ack, rdata, busy back.
//   Memory side    : eab, din_m, mem_we to the memory; dout_m from it.
//   slave  modport : the arbiter.
//   master modport : requesters + memory (the environment).
interface mem_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = mem_arb_pkg::AW_DEF,
  parameter int DW   = mem_arb_pkg::DW_DEF
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [AW-1:0]      eab;
  logic [DW-1:0]      din_m;
  logic               mem_we;
  logic [DW-1:0]      dout_m;

  modport slave (
    input  req, req_we, req_addr, req_wdata, dout_m,
    output ack, rdata, busy, eab, din_m, mem_we
  );

  modport master (
    output req, req_we, req_addr, req_wdata, dout_m,
    input  ack, rdata, busy, eab, din_m, mem_we
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select.
//   req : request vector
//   ptr : search start index (0 gives fixed priority, index 0 highest)
//   gnt : one-hot grant (all zero when no request)
//   idx : binary index of the granted requester
module arb_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  int k;

  // Walk from the farthest candidate back toward ptr; the last hit is the
  // one closest to ptr, so no early exit is needed.
  always_comb begin
    gnt = '0;
    idx = '0;
    k   = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % NREQ;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 32x16 main memory among NREQ requesters.
//   clk : system clock, all state on posedge
//   rst : asynchronous active-low reset
//   bus : mem_arbiter_if.slave (requests in, ack/rdata/busy out, registered
//         eab/din_m/mem_we to memory, dout_m from memory)
// Each access: IDLE (sample + register) -> ACCESS (memory cycle, capture
// read data) -> DONE (one-cycle ack). Optional macro MEM_ARB_RR_EN selects
// round-robin arbitration; otherwise fixed priority with index 0 highest.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 2) ? 2 : 1;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt, gnt_q, ack_q;
  logic [IW-1:0]   idx, ptr;
  logic [AW-1:0]   eab_q;
  logic [DW-1:0]   din_q, rdata_q;
  logic            we_q, busy_c;

  arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );

`ifdef MEM_ARB_RR_EN
  // Pointer moves just past the winner so the next search starts there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          ptr <= '0;
    else if (state == IDLE && |gnt)    ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state; DONE never looks at req
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy_c = (state != IDLE);
  end

  // Datapath: only the winner latched in IDLE is used afterwards, so a
  // request withdrawn mid-access still completes and is acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eab_q   <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: if (|gnt) begin
          eab_q <= bus.req_addr[int'(idx)*AW +: AW];
          din_q <= bus.req_wdata[int'(idx)*DW +: DW];
          we_q  <= |(bus.req_we & gnt);
          gnt_q <= gnt;
        end
        ACCESS: begin
          if (!we_q) rdata_q <= bus.dout_m;
          we_q  <= 1'b0;
          ack_q <= gnt_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.eab    = eab_q;
  assign bus.din_m  = din_q;
  assign bus.mem_we = we_q;
  assign bus.ack    = ack_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_c;
endmodule
